// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg
// Architectural constants shared across the RV32I cores.
//   RESET_PC  : address of the first instruction fetched after reset
//   NOP_INSTR : canonical NOP (addi x0,x0,0), used for bubbles and faults
package rv32i_types_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0200;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : rv32i_types_pkg

// File: rtl/stage3_types_pkg.sv
// stage3_types_pkg
// Types shared by the stages of the 3-stage pipeline.
//   fetch_ex_t    : fetch->execute pipeline register {valid, pc, pc4, instr, mal_fetch}
//   fetch_state_t : fetch stage FSM state
//   FETCH_BUBBLE  : empty slot carrying a NOP
//   fault_slot()  : slot that reports a misaligned fetch target to execute
package stage3_types_pkg;

  import rv32i_types_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        mal_fetch;
  } fetch_ex_t;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    FETCH_WAIT = 2'd1,
    DRAIN      = 2'd2,
    FAULT      = 2'd3
  } fetch_state_t;

  localparam fetch_ex_t FETCH_BUBBLE = '{
    valid:     1'b0,
    pc:        32'h0,
    pc4:       32'h0,
    instr:     NOP_INSTR,
    mal_fetch: 1'b0
  };

  function automatic fetch_ex_t fault_slot(input logic [31:0] target);
    fetch_ex_t slot;
    slot.valid     = 1'b1;
    slot.pc        = target;
    slot.pc4       = target + 32'd4;
    slot.instr     = NOP_INSTR;
    slot.mal_fetch = 1'b1;
    return slot;
  endfunction

endpackage : stage3_types_pkg

// File: rtl/stage3_fetch_stage.sv
// stage3_fetch_stage
// Fetch stage of the 3-stage RV32I pipeline. Owns the PC, issues reads on the
// generic imem bus and registers each returned word into fetch_ex_reg.
// Handles execute back-pressure, redirects (with discard of a stale in-flight
// response) and misaligned redirect targets.
//   CLK, RST      : clock, synchronous active-high reset
//   imem_ren      : read request, imem_addr: word-aligned fetch address
//   imem_busy     : 0 = read completes this cycle with imem_rdata valid
//   ex_stall      : execute cannot take a new fetch_ex_reg this cycle
//   brj_en/addr   : one-cycle redirect pulse and its target
//   fetch_ex_reg  : pipeline register consumed by execute
module stage3_fetch_stage
  import rv32i_types_pkg::*;
  import stage3_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        ex_stall,
  input  logic        brj_en,
  input  logic [31:0] brj_addr,
  output fetch_ex_t   fetch_ex_reg
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc_q;
  logic [31:0]  req_addr_q;
  logic         in_flight_q;
  logic         fault_sent_q;
  logic         run_q;
  logic         out_free;
  logic         complete;
  logic         pending;

  assign out_free = !fetch_ex_reg.valid || !ex_stall;
  assign complete = imem_ren && !imem_busy;
  assign pending  = imem_ren && imem_busy;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state. A redirect with a request still outstanding must drain it
  // first; DRAIN exits on the target alignment already loaded into pc_q.
  always_comb begin
    state_d = state_q;
    if (brj_en) begin
      if (pending)                     state_d = DRAIN;
      else if (brj_addr[1:0] != 2'b00) state_d = FAULT;
      else                             state_d = FETCH;
    end else begin
      case (state_q)
        FETCH:      if (complete && !out_free) state_d = FETCH_WAIT;
        FETCH_WAIT: if (imem_ren)              state_d = FETCH;
        DRAIN:      if (complete)              state_d = (pc_q[1:0] != 2'b00) ? FAULT : FETCH;
        default:    state_d = state_q;
      endcase
    end
  end

  // Bus outputs. Once a request is outstanding it is held regardless of
  // ex_stall; run_q keeps the bus quiet for the first cycle out of reset.
  always_comb begin
    imem_ren  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH: begin
        imem_ren  = in_flight_q || out_free;
        imem_addr = in_flight_q ? req_addr_q : pc_q;
      end
      FETCH_WAIT: imem_ren = out_free;
      DRAIN: begin
        imem_ren  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: imem_ren = 1'b0;
    endcase
    if (RST || !run_q) imem_ren = 1'b0;
  end

  // PC, request tracking and the fetch->execute register. A response that
  // arrives while stalled is dropped and replayed later (reads are side-effect
  // free), so the PC only advances when a word is actually captured.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      in_flight_q  <= 1'b0;
      fault_sent_q <= 1'b0;
      run_q        <= 1'b0;
      fetch_ex_reg <= FETCH_BUBBLE;
    end else begin
      run_q       <= 1'b1;
      in_flight_q <= pending;
      if (imem_ren) req_addr_q <= imem_addr;
      if (brj_en) begin
        pc_q         <= brj_addr;
        fetch_ex_reg <= FETCH_BUBBLE;
        fault_sent_q <= 1'b0;
      end else begin
        case (state_q)
          FETCH, FETCH_WAIT: begin
            if (complete && out_free) begin
              fetch_ex_reg <= '{valid: 1'b1, pc: pc_q, pc4: pc_q + 32'd4,
                                instr: imem_rdata, mal_fetch: 1'b0};
              pc_q         <= pc_q + 32'd4;
            end else if (out_free) begin
              fetch_ex_reg.valid <= 1'b0;
            end
          end
          FAULT: begin
            if (out_free) begin
              if (!fault_sent_q) begin
                fetch_ex_reg <= fault_slot(pc_q);
                fault_sent_q <= 1'b1;
              end else begin
                fetch_ex_reg.valid <= 1'b0;
              end
            end
          end
          default: if (out_free) fetch_ex_reg.valid <= 1'b0;
        endcase
      end
    end
  end

endmodule : stage3_fetch_stage

// File: tb/tb_stage3_fetch_stage.sv
// tb_stage3_fetch_stage
// Directed bench for the fetch stage: zero-wait streaming, back-pressure,
// redirect during a miss, redirect on a completion, misaligned target and
// reset in the middle of a transaction.
module tb_stage3_fetch_stage;

  import stage3_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        ex_stall;
  logic        brj_en;
  logic [31:0] brj_addr;
  fetch_ex_t   fetch_ex_reg;

  int checkCount = 0;
  int failCount  = 0;

  stage3_fetch_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem_ren     (imem_ren),
    .imem_addr    (imem_addr),
    .imem_busy    (imem_busy),
    .imem_rdata   (imem_rdata),
    .ex_stall     (ex_stall),
    .brj_en       (brj_en),
    .brj_addr     (brj_addr),
    .fetch_ex_reg (fetch_ex_reg)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction memory contents as a function of address
  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    if (addr == 32'h208) return 32'hDEAD_BEEF;
    return {addr[15:0], 16'h0F0F};
  endfunction

  assign imem_rdata = instrOf(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic ren, input logic [31:0] addr);
    checkOutput({tag, "_ren"}, {31'h0, imem_ren}, {31'h0, ren});
    if (ren) checkOutput({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic checkSlot(input string tag, input logic valid, input logic [31:0] pc,
                           input logic [31:0] instr, input logic mal);
    checkOutput({tag, "_valid"}, {31'h0, fetch_ex_reg.valid}, {31'h0, valid});
    if (valid) begin
      checkOutput({tag, "_pc"},    fetch_ex_reg.pc,  pc);
      checkOutput({tag, "_pc4"},   fetch_ex_reg.pc4, pc + 32'd4);
      checkOutput({tag, "_instr"}, fetch_ex_reg.instr, instr);
      checkOutput({tag, "_mal"},   {31'h0, fetch_ex_reg.mal_fetch}, {31'h0, mal});
    end
  endtask

  // Step past the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive this cycle's inputs and let combinational outputs settle
  task automatic applyStimulus(input logic rst, input logic busy, input logic stall,
                               input logic brj, input logic [31:0] target);
    RST       = rst;
    imem_busy = busy;
    ex_stall  = stall;
    brj_en    = brj;
    brj_addr  = target;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    // Reset state
    checkOutput("rst_valid", {31'h0, fetch_ex_reg.valid}, 32'h0);
    checkOutput("rst_instr", fetch_ex_reg.instr, 32'h0000_0013);
    checkOutput("rst_ren",   {31'h0, imem_ren}, 32'h0);

    // Zero-wait stream
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("start_gap", 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("first_req", 1'b1, 32'h200);
    checkSlot("first_req", 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkSlot($sformatf("stream%0d", i), 1'b1, 32'h200 + 32'(4 * i),
                instrOf(32'h200 + 32'(4 * i)), 1'b0);
      checkBus($sformatf("stream%0d", i), 1'b1, 32'h204 + 32'(4 * i));
    end

    // Back-pressure on the 0x208 slot
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkSlot($sformatf("stall%0d", i), 1'b1, 32'h208, 32'hDEAD_BEEF, 1'b0);
      checkBus($sformatf("stall%0d", i), 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSlot("stall_hold_end", 1'b1, 32'h208, 32'hDEAD_BEEF, 1'b0);
    checkBus("stall_release", 1'b1, 32'h20C);
    tick();
    checkSlot("after_stall", 1'b1, 32'h20C, instrOf(32'h20C), 1'b0);

    // Redirect during a 4-cycle miss at 0x210
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkBus("miss0", 1'b1, 32'h210);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
    checkBus("miss1", 1'b1, 32'h210);
    checkSlot("miss1", 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    for (int i = 2; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checkBus($sformatf("drain%0d", i), 1'b1, 32'h210);
      checkSlot($sformatf("drain%0d", i), 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("drain_done", 1'b1, 32'h210);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSlot("drain_drop", 1'b0, 32'h0, 32'h0, 1'b0);
    checkBus("redirect_req", 1'b1, 32'h400);
    tick();
    checkSlot("redirect_word", 1'b1, 32'h400, instrOf(32'h400), 1'b0);

    // Redirect in the same cycle as a completion
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
    checkBus("coincide", 1'b1, 32'h404);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSlot("coincide_drop", 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("coincide_nop", fetch_ex_reg.instr, 32'h0000_0013);
    checkBus("coincide_req", 1'b1, 32'h800);
    tick();
    checkSlot("coincide_word", 1'b1, 32'h800, instrOf(32'h800), 1'b0);

    // Misaligned redirect target
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h402);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSlot("fault_entry", 1'b0, 32'h0, 32'h0, 1'b0);
    checkBus("fault_entry", 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkSlot("fault_slot", 1'b1, 32'h402, 32'h0000_0013, 1'b1);
    checkBus("fault_slot", 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkSlot($sformatf("fault_idle%0d", i), 1'b0, 32'h0, 32'h0, 1'b0);
      checkBus($sformatf("fault_idle%0d", i), 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("trap_req", 1'b1, 32'h100);
    tick();
    checkSlot("trap_word", 1'b1, 32'h100, instrOf(32'h100), 1'b0);

    // Reset in the middle of a miss with a valid slot
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_mid_pre", {31'h0, fetch_ex_reg.valid}, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkSlot("rst_mid", 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rst_mid_instr", fetch_ex_reg.instr, 32'h0000_0013);
    checkBus("rst_mid", 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("rst_release", 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkBus("rst_restart", 1'b1, 32'h200);
    tick();
    checkSlot("rst_restart_word", 1'b1, 32'h200, instrOf(32'h200), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule : tb_stage3_fetch_stage
